ni_packetizer: RTL and testbench
================================

# ni_packetizer

Local-port packet transmitter for the 2x2 mesh router. It turns a packet descriptor and a payload word stream into a HEADER/BODY/TAIL flit sequence. It drives the request, flit ID and packet length that the output-port arbiters consume, and holds its request asserted from header to tail so the arbiter's grant timer stays with the packet. It sits between the processing element (or traffic generator) and the router's local input.

## Interface
Parameters:
- DATA_WIDTH, 32: payload bits per flit; minimum 20.
- SRC_ID, 4'd0: this node's ID, placed in every header.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pkt_valid  in  1  descriptor valid.
- pkt_dst  in  4  destination node ID.
- pkt_len  in  12  total flits including header.
- pkt_ready  out  1  descriptor accepted when pkt_valid && pkt_ready.
- data_in  in  DATA_WIDTH  payload word.
- data_valid  in  1  payload word valid.
- data_ready  out  1  payload word consumed when data_valid && data_ready.
- grant  in  1  arbiter grant to this port.
- dn_full  in  1  downstream buffer full.
- req  out  1  request to the arbiter.
- flit_id  out  3  000 idle, 001 HEADER, 010 BODY, 100 TAIL.
- length  out  12  packet length, stable while req=1.
- flit_out  out  DATA_WIDTH  flit payload.
- flit_valid  out  1  flit_out valid; a flit transfers when flit_valid && grant && !dn_full.
- busy  out  1  packet in progress (state != IDLE).

## Operation
- One-hot FSM with states IDLE, HEAD, BODY, TAIL, and a 12-bit remaining-flit counter rem.
- IDLE:
  - pkt_ready=1; all other outputs 0.
  - On accept: latch pkt_dst; set length = max(pkt_len, 2); set rem = length-1; go to HEAD.
  - pkt_len of 0 or 1 is coerced to 2 (header + tail).
- HEAD:
  - req=1, flit_valid=1, flit_id=HEADER.
  - flit_out = {length, pkt_dst, SRC_ID, zero-fill} (MSB-first).
  - On transfer: go to TAIL if rem==1, otherwise BODY.
- BODY:
  - req=1; flit_id=BODY; flit_out=data_in; flit_valid=data_valid; data_ready = grant && !dn_full.
  - On transfer: rem decrements; when rem==2, go to TAIL.
- TAIL: same as BODY but flit_id=TAIL. On transfer, go to IDLE.
- req stays 1 in HEAD/BODY/TAIL regardless of grant, dn_full or data_valid stalls. req never deasserts mid-packet.
- Grant loss mid-packet: no transfer and no counter change; resume when grant returns.
- A new descriptor is never accepted before the TAIL transfer. pkt_ready returns 1 the cycle after TAIL.
- rem never underflows. Counter arithmetic is 12-bit unsigned.

## Timing
- Reset: state=IDLE, rem=0, length=0, req=0, flit_valid=0, flit_id=000, flit_out=0, data_ready=0, busy=0, pkt_ready=1 (the cycle after rst).
- rst asserted mid-packet: aborts the packet; IDLE outputs appear on the next cycle.
- Descriptor accept to req=1: 1 cycle.
- req to HEADER transfer: the first cycle with grant && !dn_full (0 cycles if already granted).
- Throughput: 1 flit per cycle while grant=1, dn_full=0, data_valid=1. An unstalled N-flit packet occupies exactly N cycles in HEAD..TAIL.
- data_ready and flit_valid are combinational from state and inputs. state, rem and length are registered.
- Back-to-back packets: minimum 1 IDLE cycle between TAIL and the next HEADER.

## Configuration
- NI_PARITY_EN:
  - Defined: adds output flit_par (1 bit) = even parity over {flit_id, flit_out}, valid with flit_valid and 0 at reset/IDLE.
  - Undefined: port and logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle: rst high 2 cycles -> req=0, flit_id=000, pkt_ready=1, busy=0.
- pkt_dst=4'h3, pkt_len=4, grant=1, data_valid=1 with words A,B,C -> flits HEADER{length=4,dst=3,src=0}, BODY A, BODY B, TAIL C on 4 consecutive cycles; req high exactly those 4 cycles.
- pkt_len=1 -> length=2; flits HEADER then TAIL carrying the first data word; only 1 data word consumed.
- pkt_len=5, grant dropped for 3 cycles after the 2nd BODY -> req stays 1, no transfer or data_ready during the drop; then BODY, TAIL complete with the correct data order.
- dn_full=1 during HEAD for 2 cycles, then data_valid=0 for 1 cycle in BODY -> header held stable, flit_valid low that cycle, total 3 stall cycles, no flit lost or duplicated.
- rst pulse during BODY of a 6-flit packet -> next cycle IDLE outputs; a fresh descriptor is accepted and sent from HEADER. With NI_PARITY_EN, flit_par matches the parity of every transferred flit.

Source files
------------

// File: rtl/ni_packetizer.sv
// rtl/ni_packetizer.sv - local-port packetizer: descriptor + payload stream to HEADER/BODY/TAIL flits
// Optional NI_PARITY_EN adds flit_par, even parity over {flit_id, flit_out}.
module ni_packetizer #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] SRC_ID     = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  input  logic [3:0]            pkt_dst,
  input  logic [11:0]           pkt_len,
  output logic                  pkt_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  grant,
  input  logic                  dn_full,
  output logic                  req,
  output logic [2:0]            flit_id,
  output logic [11:0]           length,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  output logic                  busy
`ifdef NI_PARITY_EN
  ,
  output logic                  flit_par
`endif
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    HEAD = 4'b0010,
    BODY = 4'b0100,
    TAIL = 4'b1000
  } state_t;

  state_t                  state;
  logic [11:0]             rem;
  logic [11:0]             len_r;
  logic [3:0]              dst_r;
  logic [11:0]             len_eff;
  logic [DATA_WIDTH-1:0]   hdr_word;
  logic                    xfer;

  // A packet always carries at least a header and a tail.
  assign len_eff = (pkt_len < 12'd2) ? 12'd2 : pkt_len;
  assign xfer    = flit_valid && grant && !dn_full;

  always_comb begin
    hdr_word = '0;
    hdr_word[DATA_WIDTH-1 -: 20] = {len_r, dst_r, SRC_ID};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= 12'd0;
      len_r <= 12'd0;
      dst_r <= 4'd0;
    end else begin
      case (state)
        IDLE: if (pkt_valid) begin
          dst_r <= pkt_dst;
          len_r <= len_eff;
          rem   <= len_eff - 12'd1;
          state <= HEAD;
        end
        HEAD: if (xfer) state <= (rem == 12'd1) ? TAIL : BODY;
        BODY: if (xfer) begin
          rem <= rem - 12'd1;
          if (rem == 12'd2) state <= TAIL;
        end
        TAIL: if (xfer) begin
          rem   <= rem - 12'd1;
          len_r <= 12'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign length = len_r;

  always_comb begin
    pkt_ready  = 1'b0;
    req        = 1'b0;
    flit_id    = 3'b000;
    flit_out   = '0;
    flit_valid = 1'b0;
    data_ready = 1'b0;
    busy       = 1'b1;
    case (state)
      HEAD: begin
        req        = 1'b1;
        flit_id    = 3'b001;
        flit_out   = hdr_word;
        flit_valid = 1'b1;
      end
      BODY, TAIL: begin
        req        = 1'b1;
        flit_id    = (state == TAIL) ? 3'b100 : 3'b010;
        flit_out   = data_in;
        flit_valid = data_valid;
        data_ready = grant && !dn_full;
      end
      default: begin
        pkt_ready = 1'b1;
        busy      = 1'b0;
      end
    endcase
  end

`ifdef NI_PARITY_EN
  assign flit_par = flit_valid ? ^{flit_id, flit_out} : 1'b0;
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
// tb/tb_ni_packetizer.sv - directed self-checking bench for ni_packetizer
module tb_ni_packetizer;
  logic        clk = 1'b0;
  logic        rst, pkt_valid, pkt_ready, data_valid, data_ready;
  logic        grant, dn_full, req, flit_valid, busy;
  logic [3:0]  pkt_dst;
  logic [11:0] pkt_len, length;
  logic [31:0] data_in, flit_out;
  logic [2:0]  flit_id;
`ifdef NI_PARITY_EN
  logic        flit_par;
`endif

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int c0;

  ni_packetizer #(.DATA_WIDTH(32), .SRC_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
    .pkt_ready(pkt_ready), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .grant(grant), .dn_full(dn_full), .req(req), .flit_id(flit_id), .length(length),
    .flit_out(flit_out), .flit_valid(flit_valid), .busy(busy)
`ifdef NI_PARITY_EN
    , .flit_par(flit_par)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && data_valid && data_ready) consumed <= consumed + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, ".req"}, req, 0);
    chk({tag, ".id"}, flit_id, 0);
    chk({tag, ".out"}, flit_out, 0);
    chk({tag, ".valid"}, flit_valid, 0);
    chk({tag, ".dready"}, data_ready, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".pready"}, pkt_ready, 1);
    chk({tag, ".len"}, length, 0);
`ifdef NI_PARITY_EN
    chk({tag, ".par"}, flit_par, 0);
`endif
  endtask

  task automatic flit(input string tag, input logic [2:0] id, input logic [31:0] out,
                      input logic v, input logic dr, input logic [11:0] len);
    #1;
    chk({tag, ".req"}, req, 1);
    chk({tag, ".id"}, flit_id, id);
    chk({tag, ".out"}, flit_out, out);
    chk({tag, ".valid"}, flit_valid, v);
    chk({tag, ".dready"}, data_ready, dr);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".pready"}, pkt_ready, 0);
    chk({tag, ".len"}, length, len);
`ifdef NI_PARITY_EN
    chk({tag, ".par"}, flit_par, v ? ^{id, out} : 1'b0);
`endif
  endtask

  initial begin
    rst = 1; pkt_valid = 0; pkt_dst = 0; pkt_len = 0;
    data_in = 0; data_valid = 0; grant = 0; dn_full = 0;
    tick(); tick();
    rst = 0;
    idle_chk("reset");

    // 4-flit packet, unstalled
    grant = 1; data_valid = 1; pkt_valid = 1; pkt_dst = 4'h3; pkt_len = 12'd4;
    data_in = 32'hAAAA0001;
    idle_chk("t2.idle");
    c0 = consumed;
    tick(); pkt_valid = 0;
    flit("t2.head", 3'b001, 32'h00430000, 1, 0, 12'd4);
    tick(); flit("t2.bodyA", 3'b010, 32'hAAAA0001, 1, 1, 12'd4);
    tick(); data_in = 32'hBBBB0002; flit("t2.bodyB", 3'b010, 32'hBBBB0002, 1, 1, 12'd4);
    tick(); data_in = 32'hCCCC0003; flit("t2.tailC", 3'b100, 32'hCCCC0003, 1, 1, 12'd4);
    tick(); idle_chk("t2.end");
    chk("t2.consumed", consumed - c0, 3);

    // pkt_len=1 coerced to 2; descriptor presented while busy is ignored
    pkt_valid = 1; pkt_dst = 4'h9; pkt_len = 12'd1; data_in = 32'hDDDD0004;
    c0 = consumed;
    tick(); pkt_dst = 4'hE; pkt_len = 12'd7;
    flit("t3.head", 3'b001, 32'h00290000, 1, 0, 12'd2);
    tick(); pkt_valid = 0;
    flit("t3.tail", 3'b100, 32'hDDDD0004, 1, 1, 12'd2);
    tick(); idle_chk("t3.end");
    chk("t3.consumed", consumed - c0, 1);

    // 5 flits, grant dropped for 3 cycles after the 2nd BODY
    pkt_valid = 1; pkt_dst = 4'h2; pkt_len = 12'd5; data_in = 32'h11110001;
    c0 = consumed;
    tick(); pkt_valid = 0;
    flit("t4.head", 3'b001, 32'h00520000, 1, 0, 12'd5);
    tick(); flit("t4.b1", 3'b010, 32'h11110001, 1, 1, 12'd5);
    tick(); data_in = 32'h11110002; flit("t4.b2", 3'b010, 32'h11110002, 1, 1, 12'd5);
    tick(); grant = 0; data_in = 32'h11110003;
    for (int i = 0; i < 3; i++) begin
      flit("t4.drop", 3'b010, 32'h11110003, 1, 0, 12'd5);
      tick();
    end
    grant = 1;
    flit("t4.b3", 3'b010, 32'h11110003, 1, 1, 12'd5);
    tick(); data_in = 32'h11110004; flit("t4.tail", 3'b100, 32'h11110004, 1, 1, 12'd5);
    tick(); idle_chk("t4.end");
    chk("t4.consumed", consumed - c0, 4);

    // dn_full for 2 cycles in HEAD, data_valid low 1 cycle in BODY
    pkt_valid = 1; pkt_dst = 4'h7; pkt_len = 12'd3; data_in = 32'h22220001;
    c0 = consumed;
    tick(); pkt_valid = 0; dn_full = 1;
    flit("t5.full0", 3'b001, 32'h00370000, 1, 0, 12'd3);
    tick(); flit("t5.full1", 3'b001, 32'h00370000, 1, 0, 12'd3);
    tick(); dn_full = 0; flit("t5.head", 3'b001, 32'h00370000, 1, 0, 12'd3);
    tick(); data_valid = 0; flit("t5.nodata", 3'b010, 32'h22220001, 0, 1, 12'd3);
    tick(); data_valid = 1; flit("t5.body", 3'b010, 32'h22220001, 1, 1, 12'd3);
    tick(); data_in = 32'h22220002; flit("t5.tail", 3'b100, 32'h22220002, 1, 1, 12'd3);
    tick(); idle_chk("t5.end");
    chk("t5.consumed", consumed - c0, 2);

    // reset during BODY of a 6-flit packet, then a fresh packet
    pkt_valid = 1; pkt_dst = 4'h1; pkt_len = 12'd6; data_in = 32'h33330001;
    tick(); pkt_valid = 0;
    flit("t6.head", 3'b001, 32'h00610000, 1, 0, 12'd6);
    tick(); flit("t6.b1", 3'b010, 32'h33330001, 1, 1, 12'd6);
    tick(); data_in = 32'h33330002; flit("t6.b2", 3'b010, 32'h33330002, 1, 1, 12'd6);
    rst = 1;
    tick(); rst = 0;
    idle_chk("t6.rst");
    pkt_valid = 1; pkt_dst = 4'hF; pkt_len = 12'd2; data_in = 32'h44440001;
    c0 = consumed;
    tick(); pkt_valid = 0;
    flit("t6.head2", 3'b001, 32'h002F0000, 1, 0, 12'd2);
    tick(); flit("t6.tail2", 3'b100, 32'h44440001, 1, 1, 12'd2);
    tick(); idle_chk("t6.end");
    chk("t6.consumed", consumed - c0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
